// File: rtl/rf_write_scoreboard_if.sv
// ---------------------------------------------------------------------------
// rf_write_scoreboard_if
//
// Purpose:
//   Bundles the request, query and status signals of the register-file write
//   scoreboard so producer/consumer logic and the scoreboard share one bus.
//
// Signals:
//   C       writeback destination register
//   RF      writeback request (register-file write of C)
//   I       issue destination (instruction that will later write I)
//   IV      issue valid for I
//   Q       query address for the operand hazard check
//   E       registered one-hot write-enable vector to the register file
//   busy    registered pending-write scoreboard
//   Q_busy  combinational busy[Q]
//   npend   registered count of set busy bits
//   err     sticky protocol-error flag
//
// Modports:
//   master  drives requests/queries, observes status (pipeline control side)
//   slave   the scoreboard itself
// ---------------------------------------------------------------------------
interface rf_write_scoreboard_if #(
    parameter int ADDR_W = 5
) ();

    localparam int NREG = 2 ** ADDR_W;

    logic [ADDR_W-1:0] C;
    logic              RF;
    logic [ADDR_W-1:0] I;
    logic              IV;
    logic [ADDR_W-1:0] Q;
    logic [NREG-1:0]   E;
    logic [NREG-1:0]   busy;
    logic              Q_busy;
    logic [ADDR_W:0]   npend;
    logic              err;

    modport master (
        output C, RF, I, IV, Q,
        input  E, busy, Q_busy, npend, err
    );

    modport slave (
        input  C, RF, I, IV, Q,
        output E, busy, Q_busy, npend, err
    );

endinterface

// File: rtl/rf_write_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_write_scoreboard
//
// Purpose:
//   Tracks which architectural registers have an outstanding producer.
//   An issue (IV/I) marks its destination busy; a writeback (RF/C) clears
//   the destination and pulses a one-hot write enable to the register file
//   one cycle later. Operand hazards are checked through Q/Q_busy. Protocol
//   violations (writeback with no producer, reissue without writeback) set
//   a sticky error flag but never block the state updates.
//
// Parameters:
//   ADDR_W        register address width
//   ZERO_PROTECT  1: register 0 is hard-wired (never enabled, never busy)
//   NREG          register count, always 2**ADDR_W
//
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous active-high reset
//   bus    rf_write_scoreboard_if slave modport (requests, query, status)
// ---------------------------------------------------------------------------
module rf_write_scoreboard #(
    parameter int  ADDR_W       = 5,
    parameter int  ZERO_PROTECT = 1,
    localparam int NREG         = 2 ** ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    rf_write_scoreboard_if.slave   bus
);

    logic [NREG-1:0]  e_q;
    logic [NREG-1:0]  e_next;
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_next;
    logic [ADDR_W:0]  npend_q;
    logic [ADDR_W:0]  npend_next;
    logic             err_q;
    logic             err_next;

    logic             c_prot;
    logic             i_prot;
    logic             wb_req;
    logic             iss_req;

    // Qualify the two requests: a request aimed at a hard-wired register 0
    // is simply dropped, so it neither enables a write nor raises an error.
    always_comb begin
        c_prot  = (ZERO_PROTECT != 0) && (bus.C == '0);
        i_prot  = (ZERO_PROTECT != 0) && (bus.I == '0);
        wb_req  = bus.RF && !c_prot;
        iss_req = bus.IV && !i_prot;
    end

    // Next-state computation. The writeback clear is applied before the
    // issue set so that when both target the same register the new producer
    // wins and the register stays busy. Error checks look at the scoreboard
    // as it was before this edge.
    always_comb begin
        e_next    = '0;
        busy_next = busy_q;
        err_next  = err_q;

        if (wb_req) begin
            e_next[bus.C]    = 1'b1;
            busy_next[bus.C] = 1'b0;
            if (!busy_q[bus.C]) begin
                err_next = 1'b1;
            end
        end

        if (iss_req) begin
            busy_next[bus.I] = 1'b1;
            if (busy_q[bus.I] && !(wb_req && (bus.C == bus.I))) begin
                err_next = 1'b1;
            end
        end
    end

    // Pending count is the popcount of the next scoreboard, so it is always
    // consistent with busy after the same edge and can never wrap.
    always_comb begin
        npend_next = '0;
        for (int k = 0; k < NREG; k++) begin
            npend_next = npend_next + {{ADDR_W{1'b0}}, busy_next[k]};
        end
    end

    // State registers. Reset overrides any request sampled in the same
    // cycle, discarding pending writes and suppressing the enable pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= '0;
            busy_q  <= '0;
            npend_q <= '0;
            err_q   <= 1'b0;
        end else begin
            e_q     <= e_next;
            busy_q  <= busy_next;
            npend_q <= npend_next;
            err_q   <= err_next;
        end
    end

    // Hazard query reads the registered scoreboard only; same-cycle issue
    // or writeback is deliberately not forwarded.
    assign bus.Q_busy = busy_q[bus.Q];
    assign bus.E      = e_q;
    assign bus.busy   = busy_q;
    assign bus.npend  = npend_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_rf_write_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_rf_write_scoreboard
//
// Purpose:
//   Self-checking bench for rf_write_scoreboard (ADDR_W=5, ZERO_PROTECT=1).
//   A behavioural model keeps the set of pending registers as a plain array
//   and applies the writeback/issue rules directly; each scenario task
//   compares the DUT outputs against constants or that model.
// ---------------------------------------------------------------------------
module tb_rf_write_scoreboard;

    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic clk;
    logic reset;

    rf_write_scoreboard_if #(.ADDR_W(ADDR_W)) bus ();

    rf_write_scoreboard #(
        .ADDR_W       (ADDR_W),
        .ZERO_PROTECT (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks;
    int n_errors;

    // Behavioural model: pending set, last write enable, sticky error.
    bit          m_busy [NREG];
    bit          m_err;
    logic [31:0] m_e;
    logic [31:0] exp_busy;
    logic [5:0]  exp_npend;
    logic        exp_qbusy;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the edge happen, advance the model and
    // leave time 1 unit past the edge for the caller to sample outputs.
    task automatic cycle(input logic rst, input logic rf, input logic [4:0] c,
                         input logic iv, input logic [4:0] i, input logic [4:0] q);
        bit wb;
        bit iss;
        int cnt;
        reset   = rst;
        bus.RF  = rf;
        bus.C   = c;
        bus.IV  = iv;
        bus.I   = i;
        bus.Q   = q;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
            m_err = 1'b0;
            m_e   = 32'd0;
        end else begin
            wb  = rf && (c != 5'd0);
            iss = iv && (i != 5'd0);
            m_e = wb ? (32'd1 << c) : 32'd0;
            if (wb && !m_busy[c]) m_err = 1'b1;
            if (iss && m_busy[i] && !(rf && c == i)) m_err = 1'b1;
            if (wb)  m_busy[c] = 1'b0;
            if (iss) m_busy[i] = 1'b1;
        end
        cnt = 0;
        for (int k = 0; k < NREG; k++) begin
            exp_busy[k] = m_busy[k];
            cnt += int'(m_busy[k]);
        end
        exp_npend = 6'(cnt);
        exp_qbusy = m_busy[q];
        #1;
    endtask

    // Reset overrides simultaneous writeback/issue requests.
    task automatic test_reset();
        cycle(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 5'd4);
        n_checks++;
        if (bus.E !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_E: got %h expected %h", bus.E, 32'd0);
        end
        n_checks++;
        if (bus.busy !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_busy: got %h expected %h", bus.busy, 32'd0);
        end
        n_checks++;
        if (bus.npend !== 6'd0 || bus.err !== 1'b0 || bus.Q_busy !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_status: got npend=%0d err=%b qbusy=%b expected 0 0 0",
                     bus.npend, bus.err, bus.Q_busy);
        end
    endtask

    // Issue then writeback of register 10.
    task automatic test_issue_writeback();
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd10, 5'd10);
        n_checks++;
        if (bus.busy !== 32'h0000_0400 || bus.npend !== 6'd1 || bus.E !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL issue10: got busy=%h npend=%0d E=%h expected 00000400 1 00000000",
                     bus.busy, bus.npend, bus.E);
        end
        n_checks++;
        if (bus.Q_busy !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL issue10_qbusy: got %b expected 1", bus.Q_busy);
        end
        cycle(1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 5'd10);
        n_checks++;
        if (bus.busy !== 32'd0 || bus.npend !== 6'd0 || bus.E !== 32'h0000_0400 || bus.err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL wb10: got busy=%h npend=%0d E=%h err=%b expected 0 0 00000400 0",
                     bus.busy, bus.npend, bus.E, bus.err);
        end
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
        n_checks++;
        if (bus.E !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL wb10_pulse: got E=%h expected 00000000", bus.E);
        end
    endtask

    // Register 0 requests are dropped entirely.
    task automatic test_zero_protect();
        cycle(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
        n_checks++;
        if (bus.busy !== 32'd0 || bus.E !== 32'd0 || bus.npend !== 6'd0 || bus.err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL zero_reg: got busy=%h E=%h npend=%0d err=%b expected 0 0 0 0",
                     bus.busy, bus.E, bus.npend, bus.err);
        end
    endtask

    // Same-register issue+writeback keeps the register busy, no error;
    // then split writeback/issue on different registers.
    task automatic test_same_and_split();
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd25, 5'd25);
        cycle(1'b0, 1'b1, 5'd25, 1'b1, 5'd25, 5'd25);
        n_checks++;
        if (bus.busy !== 32'h0200_0000 || bus.E !== 32'h0200_0000 || bus.err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL same25: got busy=%h E=%h err=%b expected 02000000 02000000 0",
                     bus.busy, bus.E, bus.err);
        end
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 5'd5);
        cycle(1'b0, 1'b1, 5'd5, 1'b1, 5'd6, 5'd6);
        n_checks++;
        if (bus.busy !== 32'h0200_0040 || bus.npend !== 6'd2 || bus.E !== 32'h0000_0020 || bus.err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL split5_6: got busy=%h npend=%0d E=%h err=%b expected 02000040 2 00000020 0",
                     bus.busy, bus.npend, bus.E, bus.err);
        end
    endtask

    // Fill every non-zero register, then reset clears everything.
    task automatic test_fill();
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        for (int r = 1; r < NREG; r++) begin
            cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'(r), 5'd7);
        end
        n_checks++;
        if (bus.busy !== 32'hFFFF_FFFE || bus.npend !== 6'd31 || bus.Q_busy !== 1'b1 || bus.err !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL fill: got busy=%h npend=%0d qbusy=%b err=%b expected fffffffe 31 1 0",
                     bus.busy, bus.npend, bus.Q_busy, bus.err);
        end
        cycle(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd7);
        n_checks++;
        if (bus.busy !== 32'd0 || bus.npend !== 6'd0 || bus.Q_busy !== 1'b0 || bus.E !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL fill_reset: got busy=%h npend=%0d qbusy=%b E=%h expected 0 0 0 0",
                     bus.busy, bus.npend, bus.Q_busy, bus.E);
        end
    endtask

    // Writeback without producer and WAW reissue both set the sticky error.
    task automatic test_err_sticky();
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0);
        n_checks++;
        if (bus.E !== 32'h8000_0000 || bus.err !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL wb31_noprod: got E=%h err=%b expected 80000000 1", bus.E, bus.err);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'(k + 1), 5'd0);
            n_checks++;
            if (bus.err !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL err_sticky: got %b expected 1", bus.err);
            end
        end
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd3);
        cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd3);
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 32'h0000_0008 || bus.npend !== 6'd1) begin
            n_errors++;
            $display("[TB] FAIL waw3: got err=%b busy=%h npend=%0d expected 1 00000008 1",
                     bus.err, bus.busy, bus.npend);
        end
    endtask

    // Random traffic, every output compared against the model each cycle.
    task automatic test_random();
        logic       rst;
        logic       rf;
        logic       iv;
        logic [4:0] c;
        logic [4:0] i;
        logic [4:0] q;
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(39, 0) == 0);
            rf  = ($urandom_range(1, 0) == 1);
            iv  = ($urandom_range(1, 0) == 1);
            c   = 5'($urandom_range(7, 0));
            i   = 5'($urandom_range(7, 0));
            q   = 5'($urandom_range(7, 0));
            if ($urandom_range(3, 0) == 0) c = 5'($urandom_range(31, 0));
            if ($urandom_range(3, 0) == 0) i = 5'($urandom_range(31, 0));
            cycle(rst, rf, c, iv, i, q);
            n_checks++;
            if (bus.E !== m_e) begin
                n_errors++;
                $display("[TB] FAIL rand_E cycle %0d: got %h expected %h", n, bus.E, m_e);
            end
            n_checks++;
            if (bus.busy !== exp_busy) begin
                n_errors++;
                $display("[TB] FAIL rand_busy cycle %0d: got %h expected %h", n, bus.busy, exp_busy);
            end
            n_checks++;
            if (bus.npend !== exp_npend) begin
                n_errors++;
                $display("[TB] FAIL rand_npend cycle %0d: got %0d expected %0d", n, bus.npend, exp_npend);
            end
            n_checks++;
            if (bus.err !== m_err) begin
                n_errors++;
                $display("[TB] FAIL rand_err cycle %0d: got %b expected %b", n, bus.err, m_err);
            end
            n_checks++;
            if (bus.Q_busy !== exp_qbusy) begin
                n_errors++;
                $display("[TB] FAIL rand_qbusy cycle %0d: got %b expected %b", n, bus.Q_busy, exp_qbusy);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.RF    = 1'b0;
        bus.C     = '0;
        bus.IV    = 1'b0;
        bus.I     = '0;
        bus.Q     = '0;
        for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
        m_err     = 1'b0;
        m_e       = '0;
        exp_busy  = '0;
        exp_npend = '0;
        exp_qbusy = 1'b0;

        $display("[TB] starting rf_write_scoreboard bench");
        test_reset();
        test_issue_writeback();
        test_zero_protect();
        test_same_and_split();
        test_fill();
        test_err_sticky();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
